// File: rtl/binary_to_bcd_if.sv
// Request/result bundle for binary_to_bcd: Start/BinValue in, Busy/Done/BCDValue/Overflow out.
interface binary_to_bcd_if #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
) ();
  logic                   Start;
  logic [BIN_WIDTH-1:0]   BinValue;
  logic                   Busy;
  logic                   Done;
  logic [4*DIGITS-1:0]    BCDValue;
  logic                   Overflow;

  modport master (
    output Start, BinValue,
    input  Busy, Done, BCDValue, Overflow
  );

  modport slave (
    input  Start, BinValue,
    output Busy, Done, BCDValue, Overflow
  );
endinterface

// File: rtl/binary_to_bcd.sv
// Sequential double-dabble converter, one binary bit per clock, result packed BCD.
// Optional macro BTB_SATURATE_EN: saturate to all-9s and flag Overflow when the value does not fit.
module binary_to_bcd #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
) (
  input  logic              Clock,
  input  logic              Reset_n,
  binary_to_bcd_if.slave    bus
);

  localparam int CW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]        scr_q, scr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic [BW-1:0]        adj;
  logic [BW-1:0]        scr_shift;

  // Add-3 correction on every digit, then shift the next binary bit into the units digit.
  always_comb begin
    adj = scr_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    scr_shift = {adj[BW-2:0], bin_q[BIN_WIDTH-1]};
  end

`ifdef BTB_SATURATE_EN
  logic ovf_q, ovf_d;
  logic ovfo_q, ovfo_d;
  logic carry;
  logic ovf_final;

  assign carry     = adj[BW-1];
  assign ovf_final = ovf_q | carry;
`endif

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
`ifdef BTB_SATURATE_EN
    ovf_d   = ovf_q;
    ovfo_d  = ovfo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          bin_d   = bus.BinValue;
          scr_d   = '0;
          cnt_d   = CW'(BIN_WIDTH - 1);
          state_d = S_SHIFT;
`ifdef BTB_SATURATE_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
        bin_d = bin_q << 1;
        scr_d = scr_shift;
`ifdef BTB_SATURATE_EN
        ovf_d = ovf_final;
`endif
        // The last shift publishes straight into the output register so no partial value is ever visible.
        if (cnt_q == '0) begin
          state_d = S_DONE;
          bcd_d   = scr_shift;
`ifdef BTB_SATURATE_EN
          ovfo_d  = ovf_final;
          if (ovf_final) bcd_d = {DIGITS{4'h9}};
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

`ifdef BTB_SATURATE_EN
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ovf_q  <= 1'b0;
      ovfo_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      ovfo_q <= ovfo_d;
    end
  end

  assign bus.Overflow = ovfo_q;
`else
  assign bus.Overflow = 1'b0;
`endif

  assign bus.Busy     = (state_q == S_SHIFT);
  assign bus.Done     = (state_q == S_DONE);
  assign bus.BCDValue = bcd_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
// Bench for binary_to_bcd: table vectors, timing sequences, reset abort, random sweep with a scoreboard.
module tb_binary_to_bcd;

  logic clk;
  logic rst_n;

  binary_to_bcd_if #(.BIN_WIDTH(8),  .DIGITS(3)) if8 ();
  binary_to_bcd_if #(.BIN_WIDTH(10), .DIGITS(3)) if10 ();

  binary_to_bcd #(.BIN_WIDTH(8),  .DIGITS(3)) u8  (.Clock(clk), .Reset_n(rst_n), .bus(if8));
  binary_to_bcd #(.BIN_WIDTH(10), .DIGITS(3)) u10 (.Clock(clk), .Reset_n(rst_n), .bus(if10));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  logic [12:0] q8[$];
  logic [12:0] q10[$];

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits of v mod 1000, or all-9s plus overflow when saturating.
  function automatic logic [12:0] model(input int unsigned v);
    int unsigned m = v % 1000;
    logic [11:0] r;
`ifdef BTB_SATURATE_EN
    if (v >= 1000) return {1'b1, 12'h999};
`endif
    r[3:0]  = 4'(m % 10);
    r[7:4]  = 4'((m / 10) % 10);
    r[11:8] = 4'(m / 100);
    return {1'b0, r};
  endfunction

  function automatic bit digits_ok(input logic [11:0] b);
    bit ok = 1'b1;
    for (int i = 0; i < 3; i++) if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  always @(negedge clk) begin
    logic [12:0] e;
    if (if8.Done) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL d8_unexpected_done actual=%0h required=none", if8.BCDValue);
      end else begin
        e = q8.pop_front();
        chk("d8_bcd", 32'(if8.BCDValue), 32'(e[11:0]));
        chk("d8_ovf", 32'(if8.Overflow), 32'(e[12]));
      end
      chk("d8_digit_range", 32'(digits_ok(if8.BCDValue)), 32'd1);
    end
  end

  always @(negedge clk) begin
    logic [12:0] e;
    if (if10.Done) begin
      if (q10.size() == 0) begin
        total++; bad++;
        $display("FAIL d10_unexpected_done actual=%0h required=none", if10.BCDValue);
      end else begin
        e = q10.pop_front();
        chk("d10_bcd", 32'(if10.BCDValue), 32'(e[11:0]));
        chk("d10_ovf", 32'(if10.Overflow), 32'(e[12]));
      end
      chk("d10_digit_range", 32'(digits_ok(if10.BCDValue)), 32'd1);
    end
  end

  task automatic wait_done(input bit d10, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(d10 ? if10.Done : if8.Done) && cyc < budget);
    if (!(d10 ? if10.Done : if8.Done)) begin
      total++; bad++;
      $display("FAIL wait_done_timeout actual=no_done required=done within %0d cycles", budget);
    end
  endtask

  task automatic run8(input int unsigned v);
    int c;
    @(negedge clk);
    if8.Start = 1'b1;
    if8.BinValue = 8'(v);
    q8.push_back(model(v));
    @(negedge clk);
    if8.Start = 1'b0;
    wait_done(1'b0, 30, c);
  endtask

  task automatic run10(input int unsigned v);
    int c;
    @(negedge clk);
    if10.Start = 1'b1;
    if10.BinValue = 10'(v);
    q10.push_back(model(v));
    @(negedge clk);
    if10.Start = 1'b0;
    wait_done(1'b1, 30, c);
  endtask

  // One conversion with Busy-length and Done-position checks.
  task automatic run8_timed(input logic [7:0] v, input logic [11:0] exp);
    int busy_n, done_n, done_idx;
    busy_n = 0; done_n = 0; done_idx = -1;
    @(negedge clk);
    if8.Start = 1'b1;
    if8.BinValue = v;
    q8.push_back({1'b0, exp});
    @(negedge clk);
    if8.Start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (if8.Busy) busy_n++;
      if (if8.Done) begin done_n++; done_idx = i; end
      @(negedge clk);
    end
    chk("busy_cycles", 32'(busy_n), 32'd8);
    chk("done_pulses", 32'(done_n), 32'd1);
    chk("done_position", 32'(done_idx), 32'd8);
  endtask

  initial begin
    vec_t tbl[6];
    int c;
    logic [12:0] e10;

    tbl[0] = '{8'd255, 12'h255};
    tbl[1] = '{8'd0,   12'h000};
    tbl[2] = '{8'd9,   12'h009};
    tbl[3] = '{8'd10,  12'h010};
    tbl[4] = '{8'd99,  12'h099};
    tbl[5] = '{8'd100, 12'h100};

    rst_n = 1'b0;
    if8.Start = 1'b0;  if8.BinValue = '0;
    if10.Start = 1'b0; if10.BinValue = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    chk("reset_bcd",  32'(if8.BCDValue), 32'h000);
    chk("reset_busy", 32'(if8.Busy), 32'd0);
    chk("reset_done", 32'(if8.Done), 32'd0);
    chk("reset_ovf",  32'(if8.Overflow), 32'd0);

    for (int i = 0; i < 6; i++) run8_timed(tbl[i].bin, tbl[i].bcd);

    // Start held high: back-to-back conversions, BinValue changed during the third one.
    @(negedge clk);
    if8.Start = 1'b1;
    if8.BinValue = 8'd42;
    q8.push_back({1'b0, 12'h042});
    q8.push_back({1'b0, 12'h042});
    wait_done(1'b0, 30, c);
    chk("held_first_latency", 32'(c), 32'd9);
    wait_done(1'b0, 30, c);
    chk("held_period", 32'(c), 32'd10);
    q8.push_back({1'b0, 12'h042});
    q8.push_back({1'b0, 12'h007});
    repeat (3) @(negedge clk);
    chk("held_busy_mid", 32'(if8.Busy), 32'd1);
    if8.BinValue = 8'd7;
    wait_done(1'b0, 30, c);
    wait_done(1'b0, 30, c);
    chk("held_period2", 32'(c), 32'd10);
    if8.Start = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_after_done", 32'(if8.BCDValue), 32'h007);

    // Asynchronous reset mid-conversion aborts it.
    @(negedge clk);
    if8.Start = 1'b1;
    if8.BinValue = 8'd77;
    @(negedge clk);
    if8.Start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", 32'(if8.Busy), 32'd1);
    chk("pre_reset_bcd", 32'(if8.BCDValue), 32'h007);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(if8.Busy), 32'd0);
    chk("abort_done", 32'(if8.Done), 32'd0);
    chk("abort_bcd",  32'(if8.BCDValue), 32'h000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if8.Done) chk("abort_no_done", 32'(if8.Done), 32'd0);
    end
    run8(123);

    // Wider input where the result may not fit three digits.
    run10(1023);
    e10 = model(1023);
    repeat (4) @(negedge clk);
    chk("d10_hold_bcd", 32'(if10.BCDValue), 32'(e10[11:0]));
    chk("d10_hold_ovf", 32'(if10.Overflow), 32'(e10[12]));
    run10(999);
    repeat (2) @(negedge clk);
    chk("d10_ovf_cleared", 32'(if10.Overflow), 32'd0);

    for (int i = 0; i < 1000; i++) run8($urandom_range(0, 255));
    for (int i = 0; i < 200; i++)  run10($urandom_range(0, 1023));

    repeat (5) @(negedge clk);
    chk("q8_drained",  32'(q8.size()),  32'd0);
    chk("q10_drained", 32'(q10.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
